// File: rtl/prio_enc_seg.sv
// Registered priority encoder: samples a request vector, encodes the highest set bit,
// counts result changes (saturating) and drives active-low hex seven-segment digits.
module prio_enc_seg #(
    parameter  int WIDTH = 8,
    parameter  int NDIG  = 2,
    parameter  int CNT_W = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               hold,
    input  logic [WIDTH-1:0]   in,
    output logic [IDX_W-1:0]   out,
    output logic               valid,
    output logic [CNT_W-1:0]   chg_cnt,
    output logic [7*NDIG-1:0]  seg
);

    logic [WIDTH-1:0] in_q;
    logic [IDX_W-1:0] out_q, out_d, idx_c;
    logic             valid_q, valid_d;
    logic             en_r_q, en_r_d;
    logic [CNT_W-1:0] chg_q, chg_d;
    logic [4*NDIG-1:0] out_ext;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Later (higher) set bits overwrite earlier ones, so the top bit wins.
    always_comb begin
        idx_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_q[i]) idx_c = IDX_W'(i);
        end
    end

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        en_r_d  = en_r_q;
        chg_d   = chg_q;
        if (!hold) begin
            en_r_d = en;
            if (en && (|in_q)) begin
                out_d   = idx_c;
                valid_d = 1'b1;
            end else begin
                out_d   = '0;
                valid_d = 1'b0;
            end
            if ({valid_d, out_d} != {valid_q, out_q}) chg_d = sat_inc(chg_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q    <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            en_r_q  <= 1'b0;
            chg_q   <= '0;
        end else begin
            in_q    <= in;
            out_q   <= out_d;
            valid_q <= valid_d;
            en_r_q  <= en_r_d;
            chg_q   <= chg_d;
        end
    end

    always_comb begin
        out_ext = (4*NDIG)'(out_q);
        seg     = '1;
        for (int d = 0; d < NDIG; d++) begin
            if (!en_r_q)
                seg[7*d +: 7] = 7'b1111111;
            else if (!valid_q)
                seg[7*d +: 7] = 7'b0111111;
            else
                seg[7*d +: 7] = hex_glyph(out_ext[4*d +: 4]);
        end
    end

    assign out     = out_q;
    assign valid   = valid_q;
    assign chg_cnt = chg_q;

endmodule

// File: tb/tb_prio_enc_seg.sv
// Directed bench for prio_enc_seg: default build, a 2-bit counter build and a 32-input build.
module tb_prio_enc_seg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        en_a = 1'b0, hold_a = 1'b0;
    logic [7:0]  in_a = '0;
    logic [2:0]  out_a;
    logic        valid_a;
    logic [7:0]  cnt_a;
    logic [13:0] seg_a;

    logic        en_b = 1'b0, hold_b = 1'b0;
    logic [7:0]  in_b = '0;
    logic [2:0]  out_b;
    logic        valid_b;
    logic [1:0]  cnt_b;
    logic [13:0] seg_b;

    logic        en_c = 1'b0, hold_c = 1'b0;
    logic [31:0] in_c = '0;
    logic [4:0]  out_c;
    logic        valid_c;
    logic [7:0]  cnt_c;
    logic [13:0] seg_c;

    int errors = 0;
    int checks = 0;

    prio_enc_seg u_a (
        .clk(clk), .rst(rst), .en(en_a), .hold(hold_a), .in(in_a),
        .out(out_a), .valid(valid_a), .chg_cnt(cnt_a), .seg(seg_a)
    );

    prio_enc_seg #(.CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .hold(hold_b), .in(in_b),
        .out(out_b), .valid(valid_b), .chg_cnt(cnt_b), .seg(seg_b)
    );

    prio_enc_seg #(.WIDTH(32), .NDIG(2)) u_c (
        .clk(clk), .rst(rst), .en(en_c), .hold(hold_c), .in(in_c),
        .out(out_c), .valid(valid_c), .chg_cnt(cnt_c), .seg(seg_c)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam logic [13:0] BLANK = 14'h3FFF;
    localparam logic [13:0] DASH2 = {7'b0111111, 7'b0111111};
    int exp_b [5] = '{1, 2, 3, 3, 3};

    initial begin
        // reset with arbitrary inputs present
        en_a = 1'b1; in_a = 8'hFF;
        tick(1);
        check("rst_out",   out_a,   0);
        check("rst_valid", valid_a, 0);
        check("rst_cnt",   cnt_a,   0);
        check("rst_seg",   seg_a,   BLANK);
        rst = 1'b0;

        in_a = 8'b0010_1100;
        tick(2);
        check("enc_out",   out_a,   5);
        check("enc_valid", valid_a, 1);
        check("enc_seg",   seg_a,   {7'b1000000, 7'b0010010});
        check("enc_cnt",   cnt_a,   1);

        in_a = 8'h00;
        tick(2);
        check("zero_valid", valid_a, 0);
        check("zero_out",   out_a,   0);
        check("zero_seg",   seg_a,   DASH2);
        check("zero_cnt",   cnt_a,   2);
        en_a = 1'b0;
        tick(1);
        check("dis_seg", seg_a, BLANK);
        check("dis_cnt", cnt_a, 2);

        en_a = 1'b1; in_a = 8'h01;
        tick(2);
        check("bit0_out",   out_a,   0);
        check("bit0_valid", valid_a, 1);
        check("bit0_cnt",   cnt_a,   3);
        hold_a = 1'b1; in_a = 8'h80;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check("hold_out", out_a, 0);
        end
        check("hold_cnt", cnt_a, 3);
        hold_a = 1'b0;
        tick(1);
        check("unhold_out", out_a, 7);
        check("unhold_cnt", cnt_a, 4);
        check("unhold_seg", seg_a, {7'b1000000, 7'b1111000});

        // mid-stream reset leaves no residue
        rst = 1'b1;
        tick(1);
        check("mrst_out",   out_a,   0);
        check("mrst_valid", valid_a, 0);
        check("mrst_cnt",   cnt_a,   0);
        check("mrst_seg",   seg_a,   BLANK);
        rst = 1'b0;
        in_a = 8'hFF;
        tick(2);
        check("all_out", out_a, 7);
        check("all_cnt", cnt_a, 1);

        // 2-bit counter saturates
        en_b = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_b = (k % 2 == 0) ? 8'h01 : 8'h02;
            tick(4);
            check("sat_cnt", cnt_b, exp_b[k]);
        end

        // 32-input build, two-digit hex index
        en_c = 1'b1; in_c = 32'h0400_0008;
        tick(2);
        check("w32_out",   out_c,   26);
        check("w32_valid", valid_c, 1);
        check("w32_seg",   seg_c,   {7'b1111001, 7'b0001000});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prio_enc_seg.md
Name: prio_enc_seg

Overview:
Parametrised, registered successor to the board-level 8-to-3 priority encoder. It samples a WIDTH-bit request vector from switches and encodes the highest set bit into a binary index with a valid flag. It supports hold/freeze, counts result changes, and drives NDIG active-low seven-segment hex digits showing the index. It sits between the switch inputs and the seven-segment outputs of the board top.

Parameters:
WIDTH, 8, number of request inputs; legal range 2..256.
NDIG, 2, number of seven-seg digits for the index; NDIG*4 >= IDX_W required.
CNT_W, 8, width of the change counter.
IDX_W (localparam), $clog2(WIDTH), index width.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
en  input  1  encoder enable.
hold  input  1  freeze displayed/encoded result.
in  input  WIDTH  request vector; bit WIDTH-1 has highest priority.
out  output  IDX_W  registered index of the highest set bit.
valid  output  1  registered; 1 when en was high and at least one bit was set.
chg_cnt  output  CNT_W  saturating count of result changes.
seg  output  7*NDIG  digit i on bits [7i+6:7i], active-low, order gfedcba.

Behaviour:
- One clock, synchronous active-high reset. Reset clears in_q, out, valid, en_r and chg_cnt to 0, which makes seg all ones (blank). Reset has priority over all other inputs. A mid-operation reset takes effect at the next edge with no residue.
- Stage 1: in_q <= in every edge (hold does not affect it). This is the switch sampling register.
- Stage 2: applies on edges where hold=0.
  - en=1 and in_q!=0: out <= index of the highest set bit of in_q; valid <= 1.
  - en=1 and in_q==0: out <= 0; valid <= 0.
  - en=0: out <= 0; valid <= 0.
  - en_r <= en in all three cases.
- Latency: 2 edges from in to out/valid. en reaches en_r in 1 edge.
- hold=1: out, valid, en_r and chg_cnt keep their values, while in_q keeps sampling. On the first edge with hold=0, stage 2 loads from the current in_q.
- chg_cnt increments by 1 on any stage-2 update edge where the new {valid,out} differs from the current {valid,out}.
  - It saturates at all ones and never wraps.
  - It is cleared only by rst. Changes to en_r alone do not count.
- seg is combinational from the registered state only, with no extra latency beyond out:
  - en_r=0: every digit is 7'b1111111 (blank).
  - en_r=1, valid=0: every digit is 7'b0111111 (dash).
  - en_r=1, valid=1: digit i shows hex nibble i of out, zero-extended to 4*NDIG bits; leading zeros are displayed.
- Hex glyphs:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- No latches. Every output is fully defined for all input combinations, including X-free behaviour after reset with in=0.

Test Plan:
1. Reset: rst=1 for 1 edge with arbitrary in/en -> out=0, valid=0, chg_cnt=0, seg=14'h3FFF. Assert rst for 1 edge mid-stream -> the same values appear after that edge.
2. Default params, en=1, in=8'b00101100 held -> after 2 edges out=5, valid=1, seg[6:0]=0010010, seg[13:7]=1000000, chg_cnt=1.
3. Then in=8'h00 -> 2 edges later valid=0, out=0, both digits 0111111, chg_cnt=2. Then en=0 -> after 1 edge seg=all ones, chg_cnt stays 2.
4. en=1, in=8'h01 settled (out=0, valid=1), then hold=1 and in=8'h80 -> out stays 0 for 10 cycles and chg_cnt is unchanged. Drop hold -> after 1 edge out=7 and chg_cnt increments by 1.
5. CNT_W=2: alternate in between 8'h01 and 8'h02 every 4 cycles, 5 times -> chg_cnt reads 1,2,3,3,3 (saturated).
6. WIDTH=32, NDIG=2, in=32'h0400_0008 -> out=26 (0x1A), seg[6:0]=0001000 (A), seg[13:7]=1111001 (1).
